// File: rtl/array_arb_pkg.sv
// Shared types and widths for the Array-port arbiter; address/data defaults
// track the Array memory model types.
package array_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 16;
    localparam int unsigned INT_W_DEF  = 32;
    localparam int unsigned LOCK_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

endpackage

// File: rtl/array_arb_stats.sv
// Saturating event counter bank for the Array arbiter (accesses per port,
// denied-request cycles, forced lock releases).
module array_arb_stats #(
    parameter int unsigned STAT_W = 16
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              inc_acc0,
    input  logic              inc_acc1,
    input  logic              inc_conflict,
    input  logic              inc_timeout,
    output logic [STAT_W-1:0] stat_acc0,
    output logic [STAT_W-1:0] stat_acc1,
    output logic [STAT_W-1:0] stat_conflict,
    output logic [STAT_W-1:0] stat_timeout
);

    logic [3:0]        inc;
    logic [STAT_W-1:0] cnt [4];

    assign inc = {inc_timeout, inc_conflict, inc_acc1, inc_acc0};

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int unsigned i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (inc[i] && (cnt[i] != '1)) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign stat_acc0     = cnt[0];
    assign stat_acc1     = cnt[1];
    assign stat_conflict = cnt[2];
    assign stat_timeout  = cnt[3];

endmodule

// File: rtl/array_arb.sv
// Two-client round-robin arbiter in front of the Array memory, with optional
// locked ownership for read-modify-write. Define ARRAY_ARB_STATS_EN for counters.
module array_arb
    import array_arb_pkg::*;
#(
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned INT_W    = INT_W_DEF,
    parameter int unsigned LOCK_MAX = 8
`ifdef ARRAY_ARB_STATS_EN
    ,
    parameter int unsigned STAT_W   = 16
`endif
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              in0_ready,
    input  logic [ADDR_W-1:0] in0_addr,
    input  logic              in0_we,
    input  logic [INT_W-1:0]  in0_di,
    input  logic              in0_lock,
    output logic              in0_valid,
    output logic [INT_W-1:0]  in0,
    input  logic              in1_ready,
    input  logic [ADDR_W-1:0] in1_addr,
    input  logic              in1_we,
    input  logic [INT_W-1:0]  in1_di,
    input  logic              in1_lock,
    output logic              in1_valid,
    output logic [INT_W-1:0]  in1,
    output logic              out0_ready,
    output logic [ADDR_W-1:0] out0_addr,
    output logic              out0_we,
    output logic [INT_W-1:0]  out0_di,
    input  logic              out0_valid,
    input  logic [INT_W-1:0]  out0
`ifdef ARRAY_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_acc0,
    output logic [STAT_W-1:0] stat_acc1,
    output logic [STAT_W-1:0] stat_conflict,
    output logic [STAT_W-1:0] stat_timeout
`endif
);

    arb_state_t            state, state_nxt;
    logic                  prio, prio_nxt;
    logic [LOCK_CNT_W-1:0] lock_cnt, lock_cnt_nxt;
    logic [LOCK_CNT_W:0]   cnt_inc;
    logic                  gnt0, gnt1, acc, win_lock, lock_ok;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        case (state)
            IDLE: begin
                if (in0_ready && in1_ready) begin
                    gnt0 = ~prio;
                    gnt1 = prio;
                end else begin
                    gnt0 = in0_ready;
                    gnt1 = in1_ready;
                end
            end
            OWN0:    gnt0 = in0_ready;
            OWN1:    gnt1 = in1_ready;
            default: ;
        endcase
    end

    // Nothing is forwarded while nrst is low, so no write can leak during reset.
    always_comb begin
        out0_ready = 1'b0;
        out0_addr  = '0;
        out0_we    = 1'b0;
        out0_di    = '0;
        if (nrst) begin
            if (gnt0) begin
                out0_ready = 1'b1;
                out0_addr  = in0_addr;
                out0_we    = in0_we;
                out0_di    = in0_di;
            end else if (gnt1) begin
                out0_ready = 1'b1;
                out0_addr  = in1_addr;
                out0_we    = in1_we;
                out0_di    = in1_di;
            end
        end
    end

    assign in0_valid = nrst & gnt0 & out0_valid;
    assign in1_valid = nrst & gnt1 & out0_valid;
    assign in0       = out0;
    assign in1       = out0;

    assign acc      = out0_ready & out0_valid;
    assign win_lock = gnt0 ? in0_lock : in1_lock;
    assign cnt_inc  = {1'b0, lock_cnt} + {{LOCK_CNT_W{1'b0}}, 1'b1};
    assign lock_ok  = win_lock && (cnt_inc < (LOCK_CNT_W+1)'(LOCK_MAX));

    always_comb begin
        state_nxt    = state;
        prio_nxt     = prio;
        lock_cnt_nxt = lock_cnt;
        if (acc) begin
            // Favour whichever port did not win this access.
            prio_nxt = gnt0;
            if (lock_ok) begin
                state_nxt    = gnt0 ? OWN0 : OWN1;
                lock_cnt_nxt = cnt_inc[LOCK_CNT_W-1:0];
            end else begin
                state_nxt    = IDLE;
                lock_cnt_nxt = '0;
            end
        end else if (((state == OWN0) && !in0_lock) || ((state == OWN1) && !in1_lock)) begin
            state_nxt    = IDLE;
            lock_cnt_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state    <= IDLE;
            prio     <= 1'b0;
            lock_cnt <= '0;
        end else begin
            state    <= state_nxt;
            prio     <= prio_nxt;
            lock_cnt <= lock_cnt_nxt;
        end
    end

`ifdef ARRAY_ARB_STATS_EN
    logic conflict, timeout;

    assign conflict = (in0_ready & ~gnt0) | (in1_ready & ~gnt1);
    assign timeout  = acc & win_lock & ~lock_ok;

    array_arb_stats #(
        .STAT_W(STAT_W)
    ) u_stats (
        .clk          (clk),
        .nrst         (nrst),
        .inc_acc0     (acc & gnt0),
        .inc_acc1     (acc & gnt1),
        .inc_conflict (conflict),
        .inc_timeout  (timeout),
        .stat_acc0    (stat_acc0),
        .stat_acc1    (stat_acc1),
        .stat_conflict(stat_conflict),
        .stat_timeout (stat_timeout)
    );
`endif

endmodule

// File: tb/tb_array_arb.sv
// Scoreboard bench for array_arb (LOCK_MAX=4) against an async-read,
// sync-write memory with data[i]=i; stats checked when ARRAY_ARB_STATS_EN is set.
module tb_array_arb;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = 16;

    typedef struct packed {
        logic          r;
        logic [AW-1:0] a;
        logic          w;
        logic [DW-1:0] d;
        logic          l;
    } req_t;

    typedef struct {
        string         tag;
        logic          v0;
        logic          v1;
        logic [DW-1:0] d;
    } exp_t;

    logic          clk = 1'b0;
    logic          nrst;
    logic          in0_ready, in0_we, in0_lock, in0_valid;
    logic [AW-1:0] in0_addr;
    logic [DW-1:0] in0_di, in0;
    logic          in1_ready, in1_we, in1_lock, in1_valid;
    logic [AW-1:0] in1_addr;
    logic [DW-1:0] in1_di, in1;
    logic          out0_ready, out0_we, out0_valid;
    logic [AW-1:0] out0_addr;
    logic [DW-1:0] out0_di, out0;
    logic          stall;
    logic [DW-1:0] mem [256];
`ifdef ARRAY_ARB_STATS_EN
    logic [SW-1:0] stat_acc0, stat_acc1, stat_conflict, stat_timeout;
`endif

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    array_arb #(
        .ADDR_W  (AW),
        .INT_W   (DW),
        .LOCK_MAX(4)
`ifdef ARRAY_ARB_STATS_EN
        ,
        .STAT_W  (SW)
`endif
    ) dut (
        .clk       (clk),
        .nrst      (nrst),
        .in0_ready (in0_ready),
        .in0_addr  (in0_addr),
        .in0_we    (in0_we),
        .in0_di    (in0_di),
        .in0_lock  (in0_lock),
        .in0_valid (in0_valid),
        .in0       (in0),
        .in1_ready (in1_ready),
        .in1_addr  (in1_addr),
        .in1_we    (in1_we),
        .in1_di    (in1_di),
        .in1_lock  (in1_lock),
        .in1_valid (in1_valid),
        .in1       (in1),
        .out0_ready(out0_ready),
        .out0_addr (out0_addr),
        .out0_we   (out0_we),
        .out0_di   (out0_di),
        .out0_valid(out0_valid),
        .out0      (out0)
`ifdef ARRAY_ARB_STATS_EN
        ,
        .stat_acc0    (stat_acc0),
        .stat_acc1    (stat_acc1),
        .stat_conflict(stat_conflict),
        .stat_timeout (stat_timeout)
`endif
    );

    // Memory model: async read, write on a granted clock edge.
    assign out0       = mem[out0_addr[7:0]];
    assign out0_valid = out0_ready & ~stall;

    always @(posedge clk) begin
        if (out0_ready && out0_valid && out0_we) mem[out0_addr[7:0]] <= out0_di;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic req_t rd(input int unsigned a, input logic l);
        req_t q;
        q   = '0;
        q.r = 1'b1;
        q.a = AW'(a);
        q.l = l;
        return q;
    endfunction

    function automatic req_t wr(input int unsigned a, input int unsigned d, input logic l);
        req_t q;
        q   = rd(a, l);
        q.w = 1'b1;
        q.d = DW'(d);
        return q;
    endfunction

    function automatic req_t hold_lock();
        req_t q;
        q   = '0;
        q.l = 1'b1;
        return q;
    endfunction

    task automatic apply(input req_t p0, input req_t p1);
        in0_ready = p0.r; in0_addr = p0.a; in0_we = p0.w; in0_di = p0.d; in0_lock = p0.l;
        in1_ready = p1.r; in1_addr = p1.a; in1_we = p1.w; in1_di = p1.d; in1_lock = p1.l;
    endtask

    // One cycle of stimulus; the expectation is queued and checked at the next negedge.
    task automatic cyc(input string tag, input req_t p0, input req_t p1, input logic st,
                       input logic e0, input logic e1, input int unsigned ed);
        exp_t e;
        apply(p0, p1);
        stall = st;
        e.tag = tag; e.v0 = e0; e.v1 = e1; e.d = DW'(ed);
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic rst_checks(input string tag);
        chk({tag, ".out0_ready"}, 64'(out0_ready), 64'd0);
        chk({tag, ".out0_we"},    64'(out0_we),    64'd0);
        chk({tag, ".out0_addr"},  64'(out0_addr),  64'd0);
        chk({tag, ".out0_di"},    64'(out0_di),    64'd0);
        chk({tag, ".in0_valid"},  64'(in0_valid),  64'd0);
        chk({tag, ".in1_valid"},  64'(in1_valid),  64'd0);
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            chk({mon_e.tag, ".v0"}, 64'(in0_valid), 64'(mon_e.v0));
            chk({mon_e.tag, ".v1"}, 64'(in1_valid), 64'(mon_e.v1));
            if (mon_e.v0) chk({mon_e.tag, ".in0"}, 64'(in0), 64'(mon_e.d));
            if (mon_e.v1) chk({mon_e.tag, ".in1"}, 64'(in1), 64'(mon_e.d));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] <= DW'(i);
        stall = 1'b0;
        nrst  = 1'b0;
        apply(wr(30, 32'hdead, 1'b1), rd(7, 1'b0));
        repeat (2) begin
            @(negedge clk);
            rst_checks("rst0");
        end
        @(posedge clk); #1;
        nrst = 1'b1;

        cyc("alt0", rd(2, 0), rd(7, 0), 0, 1, 0, 2);
        cyc("alt1", rd(2, 0), rd(7, 0), 0, 0, 1, 7);
        cyc("alt2", rd(2, 0), rd(7, 0), 0, 1, 0, 2);
        cyc("alt3", rd(2, 0), rd(7, 0), 0, 0, 1, 7);
        cyc("solo1", '0, rd(6, 0), 0, 0, 1, 6);
        cyc("solo0", rd(5, 0), '0, 0, 1, 0, 5);
        cyc("idle", '0, '0, 0, 0, 0, 0);

        // Port 1 locked read-modify-write of addr 3 while port 0 keeps asking.
        cyc("rmw_rd", rd(3, 0), rd(3, 1), 0, 0, 1, 3);
        cyc("rmw_wr", rd(3, 0), wr(3, 4, 0), 0, 0, 1, 3);
        cyc("rmw_p0", rd(3, 0), '0, 0, 1, 0, 4);

        cyc("stall", rd(10, 0), rd(11, 0), 1, 0, 0, 0);
        cyc("unstall", rd(10, 0), rd(11, 0), 0, 0, 1, 11);

        for (int i = 0; i < 10; i++) begin
            if (i == 4 || i == 9) cyc("tmo", rd(1, 1), rd(9, 0), 0, 0, 1, 9);
            else                  cyc("tmo", rd(1, 1), rd(9, 0), 0, 1, 0, 1);
        end

        // Idle owner cycles hold ownership without using up the lock budget.
        cyc("own1", rd(12, 1), rd(13, 0), 0, 1, 0, 12);
        cyc("hold_a", hold_lock(), rd(13, 0), 0, 0, 0, 0);
        cyc("hold_b", hold_lock(), rd(13, 0), 0, 0, 0, 0);
        cyc("own2", rd(12, 1), rd(13, 0), 0, 1, 0, 12);
        cyc("own3", rd(12, 1), rd(13, 0), 0, 1, 0, 12);
        cyc("own4", rd(12, 1), rd(13, 0), 0, 1, 0, 12);
        cyc("after_tmo", rd(12, 0), rd(13, 0), 0, 0, 1, 13);

        cyc("rel_a", rd(14, 1), '0, 0, 1, 0, 14);
        cyc("rel_b", '0, rd(15, 0), 0, 0, 0, 0);
        cyc("rel_c", '0, rd(15, 0), 0, 0, 1, 15);
`ifdef ARRAY_ARB_STATS_EN
        chk("stat_timeout_3", 64'(stat_timeout), 64'd3);
`endif

        // Reset while port 0 owns the array with a write pending.
        cyc("own_pre_rst", rd(20, 1), '0, 0, 1, 0, 20);
        apply(wr(20, 99, 1), '0);
        nrst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            rst_checks("rst_own");
        end
        @(posedge clk); #1;
        chk("rst_no_write", 64'(mem[20]), 64'd20);
        nrst = 1'b1;
        cyc("post_rst_idle", '0, rd(21, 0), 0, 0, 1, 21);

        cyc("pre_rst2", rd(22, 0), '0, 0, 1, 0, 22);
        apply('0, '0);
        nrst = 1'b0;
        @(negedge clk);
        rst_checks("rst_prio");
        @(posedge clk); #1;
        nrst = 1'b1;
        cyc("post_rst_prio", rd(2, 0), rd(7, 0), 0, 1, 0, 2);
        cyc("no_wr", rd(20, 0), '0, 0, 1, 0, 20);

        apply('0, '0);
        nrst = 1'b0;
        @(posedge clk); #1;
        nrst = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (i % 2 == 0) cyc("cont", rd(2, 0), rd(7, 0), 0, 1, 0, 2);
            else            cyc("cont", rd(2, 0), rd(7, 0), 0, 0, 1, 7);
        end
        apply('0, '0);
`ifdef ARRAY_ARB_STATS_EN
        chk("stat_acc0", 64'(stat_acc0), 64'd50);
        chk("stat_acc1", 64'(stat_acc1), 64'd50);
        chk("stat_conflict", 64'(stat_conflict), 64'd100);
        chk("stat_timeout_0", 64'(stat_timeout), 64'd0);
`endif
        if (sb.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
